branch_seq: RTL
===============

BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the taken-branch statistics counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  control-transfer request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port req_type  input  2  00 branch, 01 JAL, 10 JALR, 11 reserved.
REQ-007 SHALL have port req_func3  input  3  instruction bits [14:12].
REQ-008 SHALL have ports req_pc, req_op1, req_op2, req_imm  input  32 each  PC, rs1, rs2, sign-extended immediate.
REQ-009 SHALL have port redirect_valid  output  1  new PC offered to fetch.
REQ-010 SHALL have port redirect_ready  input  1  fetch accepts the redirect.
REQ-011 SHALL have port redirect_pc  output  32  target PC.
REQ-012 SHALL have port flush  output  1  one-cycle pulse that kills younger instructions.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a request completes.
REQ-014 SHALL have port link_data  output  32  captured PC+4 for JAL/JALR, else 0.
REQ-015 SHALL have port exc  output  2  valid with done: 00 none, 01 illegal, 10 misaligned target.
REQ-016 SHALL have port taken_cnt  output  CNT_W  saturating count of completed redirects.

Function
REQ-017 SHALL use FSM states IDLE, EVAL, REDIR; req_ready = 1 only in IDLE.
REQ-018 SHALL, on req_valid and req_ready in IDLE, register all req_* inputs and enter EVAL next cycle.
REQ-019 SHALL in EVAL resolve the branch condition from the registered operands: func3 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
REQ-020 SHALL treat JAL and JALR as always taken.
REQ-021 SHALL compute the target as pc+imm for branch/JAL and (op1+imm) with bit 0 cleared for JALR, modulo 2^32 (wrap-around allowed, no error).
REQ-022 SHALL flag illegal when req_type=11, branch func3 is 010 or 011, or JALR func3 is not 000; it then pulses done with exc=01 in EVAL, with no flush or redirect, and returns to IDLE.
REQ-023 SHALL flag misaligned when the taken target has bit 1 set; it then pulses done with exc=10 in EVAL, with no flush or redirect, and returns to IDLE.
REQ-024 SHALL, when not taken and legal, pulse done with exc=00 in EVAL and return to IDLE; total latency is 2 cycles from acceptance.
REQ-025 SHALL, when taken and legal, pulse flush in EVAL, enter REDIR, and drive redirect_valid=1 with a stable redirect_pc until redirect_ready.
REQ-026 SHALL, on redirect_valid and redirect_ready in REDIR, pulse done with exc=00, increment taken_cnt unless it is all-ones, and return to IDLE.
REQ-027 SHALL NOT let redirect_valid fall or redirect_pc change while waiting for redirect_ready.
REQ-028 SHALL hold link_data from EVAL until the next acceptance.
REQ-029 SHALL ignore req_valid outside IDLE, with no effect on state.

Reset
REQ-030 SHALL, on rst_n low, immediately enter IDLE and clear all registers: req_ready=1 once in IDLE; redirect_valid, flush, done, exc, redirect_pc, link_data and taken_cnt all 0.
REQ-031 SHALL abandon any in-flight request on reset mid-operation, with no done or redirect after release.

Structure
REQ-032 SHALL take req_type codes, exc codes, func3 encodings and FSM state encodings from a shared package, branch_pkg.
REQ-033 SHALL instantiate one combinational sub-module, br_cond, that maps (func3, op1, op2) to taken/illegal.

Verification
REQ-034 SHALL test BEQ with op1=op2=5, pc=0x100, imm=0x20: flush in EVAL, redirect_pc=0x120 held through 3 stall cycles, done on handshake, taken_cnt=1.
REQ-035 SHALL test BLT with op1=0xFFFFFFFF, op2=1 (taken, signed), then BLTU with the same operands: not taken, done 2 cycles after acceptance, no flush.
REQ-036 SHALL test JALR with op1=0x1003, imm=0, pc=0x40: redirect_pc=0x1002 gives exc=10 and no redirect; with op1=0x1001 it gives redirect_pc=0x1000 and link_data=0x44.
REQ-037 SHALL test func3=010 and req_type=11: done with exc=01, no flush, taken_cnt unchanged.
REQ-038 SHALL test CNT_W=4 with 17 taken branches: taken_cnt saturates at 15.
REQ-039 SHALL test rst_n low while in REDIR: redirect_valid drops immediately, and after release the state is IDLE with no spurious done.

Source files
------------

// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
// Shared encodings for the branch sequencer: request type codes, exception
// codes, branch func3 encodings, FSM state encodings and the registered
// request record.
// ----------------------------------------------------------------------------
package branch_pkg;

    // Request type (req_type)
    localparam logic [1:0] REQ_BRANCH = 2'b00;
    localparam logic [1:0] REQ_JAL    = 2'b01;
    localparam logic [1:0] REQ_JALR   = 2'b10;
    localparam logic [1:0] REQ_RSVD   = 2'b11;

    // Exception code (exc), meaningful only while done is high
    localparam logic [1:0] EXC_NONE   = 2'b00;
    localparam logic [1:0] EXC_ILL    = 2'b01;
    localparam logic [1:0] EXC_MIS    = 2'b10;

    // Branch func3 encodings (instruction bits [14:12])
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;
    // JALR only defines func3 = 000
    localparam logic [2:0] F3_JALR    = 3'b000;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EVAL    = 2'd1;
    localparam logic [1:0] ST_REDIR   = 2'd2;

    // Request captured on acceptance
    typedef struct packed {
        logic [1:0]  rtype;
        logic [2:0]  func3;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
    } req_t;

endpackage : branch_pkg

// File: rtl/br_cond.sv
// ----------------------------------------------------------------------------
// br_cond
// Combinational branch-condition resolver for conditional branches.
//   func3   : branch encoding (bits [14:12])
//   op1/op2 : rs1 / rs2 operand values
//   taken   : condition holds (0 whenever illegal)
//   illegal : func3 is not a defined branch encoding (010, 011)
// ----------------------------------------------------------------------------
module br_cond
    import branch_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        taken,
    output logic        illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (func3)
            F3_BEQ:  taken = (op1 == op2);
            F3_BNE:  taken = (op1 != op2);
            F3_BLT:  taken = ($signed(op1) <  $signed(op2));
            F3_BGE:  taken = ($signed(op1) >= $signed(op2));
            F3_BLTU: taken = (op1 <  op2);
            F3_BGEU: taken = (op1 >= op2);
            default: illegal = 1'b1;
        endcase
    end

endmodule : br_cond

// File: rtl/branch_seq.sv
// ----------------------------------------------------------------------------
// branch_seq
// Control-transfer sequencer: accepts one branch/JAL/JALR request, resolves
// it, and either completes immediately (not taken / exception) or flushes and
// offers a redirect to fetch until it is accepted.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps valid (and payload) stable until that edge;
// the consumer may change ready freely. Here req_* is consumed and
// redirect_* is produced.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_type/func3    : transfer kind and instruction bits [14:12]
//   req_pc/op1/op2/imm: PC, rs1, rs2, sign-extended immediate
//   redirect_valid/ready/pc : new PC offered to fetch
//   flush             : one-cycle kill of younger instructions
//   done / exc        : one-cycle completion pulse and its exception code
//   link_data         : PC+4 for JAL/JALR, else 0; held until next acceptance
//   taken_cnt         : saturating count of completed redirects
//   dbg_state         : current FSM state
// ----------------------------------------------------------------------------
module branch_seq
    import branch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_type,
    input  logic [2:0]       req_func3,
    input  logic [31:0]      req_pc,
    input  logic [31:0]      req_op1,
    input  logic [31:0]      req_op2,
    input  logic [31:0]      req_imm,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             done,
    output logic [31:0]      link_data,
    output logic [1:0]       exc,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [1:0]       dbg_state
);

    logic [1:0]       state_q, state_d;
    req_t             req_q;
    logic [31:0]      link_q;
    logic [31:0]      rpc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             redir_fire;
    logic             br_taken, br_illegal;
    logic             is_taken, is_illegal;
    logic [31:0]      target;
    logic [31:0]      jalr_sum;
    logic             misaligned;
    logic             go_redir;

    br_cond u_br_cond (
        .func3   (req_q.func3),
        .op1     (req_q.op1),
        .op2     (req_q.op2),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    assign accept     = req_valid && (state_q == ST_IDLE);
    assign redir_fire = (state_q == ST_REDIR) && redirect_ready;

    // Resolution of the registered request; only consumed in EVAL.
    always_comb begin
        is_taken   = 1'b0;
        is_illegal = 1'b0;
        jalr_sum   = req_q.op1 + req_q.imm;
        target     = req_q.pc + req_q.imm;
        case (req_q.rtype)
            REQ_BRANCH: begin
                is_taken   = br_taken;
                is_illegal = br_illegal;
            end
            REQ_JAL: begin
                is_taken   = 1'b1;
            end
            REQ_JALR: begin
                is_taken   = 1'b1;
                is_illegal = (req_q.func3 != F3_JALR);
                target     = jalr_sum & 32'hFFFF_FFFE;
            end
            default: begin
                is_illegal = 1'b1;
            end
        endcase
        // Alignment only matters for a transfer that would actually happen.
        misaligned = is_taken && !is_illegal && target[1];
        go_redir   = is_taken && !is_illegal && !target[1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)     state_d = ST_EVAL;
            ST_EVAL:  state_d = go_redir ? ST_REDIR : ST_IDLE;
            ST_REDIR: if (redir_fire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            link_q  <= '0;
            rpc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q.rtype <= req_type;
                req_q.func3 <= req_func3;
                req_q.pc    <= req_pc;
                req_q.op1   <= req_op1;
                req_q.op2   <= req_op2;
                req_q.imm   <= req_imm;
                // Link value is captured at acceptance so it is already
                // visible in EVAL and stays put until the next request.
                link_q      <= ((req_type == REQ_JAL) || (req_type == REQ_JALR))
                               ? (req_pc + 32'd4) : 32'd0;
            end
            // Target is frozen on entry to REDIR so it cannot move while
            // fetch stalls.
            if ((state_q == ST_EVAL) && go_redir) begin
                rpc_q <= target;
            end
            if (redir_fire && !(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        redirect_valid = (state_q == ST_REDIR);
        redirect_pc    = rpc_q;
        flush          = (state_q == ST_EVAL) && go_redir;
        done           = ((state_q == ST_EVAL) && !go_redir) || redir_fire;
        exc            = EXC_NONE;
        if (state_q == ST_EVAL) begin
            if (is_illegal)      exc = EXC_ILL;
            else if (misaligned) exc = EXC_MIS;
        end
        link_data      = link_q;
        taken_cnt      = cnt_q;
        dbg_state      = state_q;
    end

endmodule : branch_seq
